// File: rtl/pedestrian_unit_if.sv
// Pedestrian terminal bus: raw button and returned lamp pair in, request/lamps/status out.
// The unit side uses the slave modport; the intersection/harness side uses master.
interface pedestrian_unit_if #(
    parameter int WAIT_W = 16
);
    logic              button;
    logic              light_green;
    logic              light_red;
    logic              request;
    logic              wait_lamp;
    logic              walk_lamp;
    logic              dont_walk_lamp;
    logic              starved;
    logic              fault;
    logic [WAIT_W-1:0] last_wait;

    modport master (
        output button, light_green, light_red,
        input  request, wait_lamp, walk_lamp, dont_walk_lamp, starved, fault, last_wait
    );

    modport slave (
        input  button, light_green, light_red,
        output request, wait_lamp, walk_lamp, dont_walk_lamp, starved, fault, last_wait
    );
endinterface

// File: rtl/pedestrian_unit.sv
// Pedestrian terminal: debounced button latched into a held request, lamp drive and fault/starve flags.
// Define PEDESTRIAN_UNIT_STATS_EN to keep the last_wait capture register; otherwise last_wait reads 0.
//
// state   | meaning
// IDLE    | no request pending, waiting for a press while green is off
// REQUEST | request held toward the intersection, wait counter running
// CROSS   | green granted, request dropped, waiting for green to end
// HOLD    | holdoff after green; presses ignored until the counter expires
module pedestrian_unit #(
    parameter int DEBOUNCE = 4,
    parameter int HOLDOFF  = 4,
    parameter int TIMEOUT  = 1000,
    parameter int WAIT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    pedestrian_unit_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int HO_W = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {IDLE, REQUEST, CROSS, HOLD} state_t;

    state_t            state, state_next;
    logic              sync_1, btn_s;
    logic              deb, deb_q;
    logic [DB_W-1:0]   cnt;
    logic              press;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [HO_W-1:0]   hold_cnt, hold_next;
    logic              request_q;
    logic              walk_q, walk_next;
    logic              fault_q, fault_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= bus.button;
            btn_s  <= sync_1;
        end
    end

    // A new level must persist DEBOUNCE synchronized cycles before deb follows it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            deb_q <= deb;
            if (btn_s == deb) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
                deb <= btn_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    assign press = deb && !deb_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            hold_cnt  <= '0;
            request_q <= 1'b0;
            walk_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            hold_cnt  <= hold_next;
            request_q <= (state_next == REQUEST);
            walk_q    <= walk_next;
            fault_q   <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                if (press && !bus.light_green) begin
                    state_next = REQUEST;
                    wait_next  = '0;
                end
            end
            REQUEST: begin
                if (wait_cnt != '1) wait_next = wait_cnt + WAIT_W'(1);
                if (bus.light_green) state_next = CROSS;
            end
            CROSS: begin
                if (!bus.light_green) begin
                    state_next = HOLD;
                    hold_next  = HO_W'(HOLDOFF - 1);
                end
            end
            HOLD: begin
                if (hold_cnt == '0) state_next = IDLE;
                else                hold_next  = hold_cnt - HO_W'(1);
            end
        endcase

        // A lamp pair showing both or neither is inconsistent; the fault blanks WALK the same cycle.
        fault_next = fault_q || (bus.light_green == bus.light_red);
        walk_next  = bus.light_green && !bus.light_red && !fault_next;
    end

`ifdef PEDESTRIAN_UNIT_STATS_EN
    logic              capture;
    logic [WAIT_W-1:0] last_wait_q;

    assign capture = (state == REQUEST) && bus.light_green;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        last_wait_q <= '0;
        else if (capture) last_wait_q <= wait_cnt;
    end

    assign bus.last_wait = last_wait_q;
`else
    assign bus.last_wait = '0;
`endif

    assign bus.request        = request_q;
    assign bus.wait_lamp      = request_q;
    assign bus.walk_lamp      = walk_q;
    assign bus.dont_walk_lamp = !walk_q;
    assign bus.fault          = fault_q;
    assign bus.starved        = (state == REQUEST) && (wait_cnt >= WAIT_W'(TIMEOUT));
endmodule

// File: tb/tb_pedestrian_unit.sv
// Directed bench for pedestrian_unit at default parameters; edge numbers are counted from origin().
module tb_pedestrian_unit;
    localparam int WAIT_W = 16;

`ifdef PEDESTRIAN_UNIT_STATS_EN
    localparam logic [WAIT_W-1:0] LW_BASIC  = 16'd20;
    localparam logic [WAIT_W-1:0] LW_STARVE = 16'd1003;
`else
    localparam logic [WAIT_W-1:0] LW_BASIC  = 16'd0;
    localparam logic [WAIT_W-1:0] LW_STARVE = 16'd0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

    pedestrian_unit_if #(.WAIT_W(WAIT_W)) bus ();

    pedestrian_unit #(
        .DEBOUNCE(4),
        .HOLDOFF (4),
        .TIMEOUT (1000),
        .WAIT_W  (WAIT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic origin();
        edge_n = -1;
    endtask

    task automatic tick_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        bus.button      = 1'b0;
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.button      = 1'b0;
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        #2;
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL reset_request: got %b want 0", bus.request); end
        checks++; if (bus.wait_lamp !== 1'b0) begin errors++; $display("FAIL reset_wait_lamp: got %b want 0", bus.wait_lamp); end
        checks++; if (bus.walk_lamp !== 1'b0) begin errors++; $display("FAIL reset_walk: got %b want 0", bus.walk_lamp); end
        checks++; if (bus.dont_walk_lamp !== 1'b1) begin errors++; $display("FAIL reset_dont_walk: got %b want 1", bus.dont_walk_lamp); end
        checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL reset_starved: got %b want 0", bus.starved); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        checks++; if (bus.last_wait !== 16'd0) begin errors++; $display("FAIL reset_last_wait: got %0d want 0", bus.last_wait); end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        origin();
        bus.button = 1'b1;
        tick();
        tick_to(5);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL basic_req_edge5: got %b want 0", bus.request); end
        tick_to(6);
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL basic_req_edge6: got %b want 1", bus.request); end
        checks++; if (bus.wait_lamp !== 1'b1) begin errors++; $display("FAIL basic_wait_edge6: got %b want 1", bus.wait_lamp); end
        tick_to(9);
        bus.button = 1'b0;
        tick_to(26);
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL basic_req_held: got %b want 1", bus.request); end
        checks++; if (bus.dont_walk_lamp !== 1'b1) begin errors++; $display("FAIL basic_dont_walk_pre: got %b want 1", bus.dont_walk_lamp); end
        bus.light_green = 1'b1;
        bus.light_red   = 1'b0;
        tick_to(27);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL basic_req_served: got %b want 0", bus.request); end
        checks++; if (bus.wait_lamp !== 1'b0) begin errors++; $display("FAIL basic_wait_served: got %b want 0", bus.wait_lamp); end
        checks++; if (bus.walk_lamp !== 1'b1) begin errors++; $display("FAIL basic_walk_on: got %b want 1", bus.walk_lamp); end
        checks++; if (bus.dont_walk_lamp !== 1'b0) begin errors++; $display("FAIL basic_dont_walk_off: got %b want 0", bus.dont_walk_lamp); end
        checks++; if (bus.last_wait !== LW_BASIC) begin errors++; $display("FAIL basic_last_wait: got %0d want %0d", bus.last_wait, LW_BASIC); end
        tick_to(31);
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        tick_to(32);
        checks++; if (bus.walk_lamp !== 1'b0) begin errors++; $display("FAIL basic_walk_off: got %b want 0", bus.walk_lamp); end
        tick_to(40);
    endtask

    task automatic test_glitch();
        logic seen;
        for (int len = 2; len <= 4; len++) begin
            apply_reset();
            origin();
            seen = 1'b0;
            bus.button = 1'b1;
            for (int k = 0; k < len; k++) tick();
            bus.button = 1'b0;
            while (edge_n < 6) begin
                tick();
                seen = seen | bus.request;
            end
            if (len < 4) begin
                tick_to(15);
                seen = seen | bus.request;
                checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_len%0d_request: got %b want 0", len, seen); end
                checks++; if (dut.deb !== 1'b0) begin errors++; $display("FAIL glitch_len%0d_deb: got %b want 0", len, dut.deb); end
            end else begin
                checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL glitch_len4_request: got %b want 1", bus.request); end
            end
        end
    endtask

    task automatic test_green_press();
        apply_reset();
        bus.light_green = 1'b1;
        bus.light_red   = 1'b0;
        tick();
        origin();
        bus.button = 1'b1;
        tick();
        tick_to(7);
        checks++; if (dut.deb !== 1'b1) begin errors++; $display("FAIL green_press_deb: got %b want 1", dut.deb); end
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL green_press_request: got %b want 0", bus.request); end
        checks++; if (bus.walk_lamp !== 1'b1) begin errors++; $display("FAIL green_press_walk: got %b want 1", bus.walk_lamp); end
        bus.button = 1'b0;
        tick_to(20);
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        tick_to(25);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL green_press_after: got %b want 0", bus.request); end
    endtask

    task automatic test_holdoff();
        apply_reset();
        origin();
        bus.button = 1'b1;
        tick();
        tick_to(5);
        bus.button = 1'b0;
        tick_to(6);
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL hold_first_request: got %b want 1", bus.request); end
        tick_to(11);
        bus.light_green = 1'b1;
        bus.light_red   = 1'b0;
        tick_to(12);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL hold_served: got %b want 0", bus.request); end
        bus.button = 1'b1;
        tick_to(14);
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        tick_to(15);
        checks++; if (bus.walk_lamp !== 1'b0) begin errors++; $display("FAIL hold_walk_off: got %b want 0", bus.walk_lamp); end
        tick_to(18);
        bus.button = 1'b0;
        tick_to(19);
        checks++; if (dut.deb !== 1'b1) begin errors++; $display("FAIL hold_press_deb: got %b want 1", dut.deb); end
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL hold_press_ignored: got %b want 0", bus.request); end
        tick_to(21);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL hold_press_ignored_late: got %b want 0", bus.request); end
        tick_to(24);
        bus.button = 1'b1;
        tick_to(30);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL hold_repress_early: got %b want 0", bus.request); end
        tick_to(31);
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL hold_repress_request: got %b want 1", bus.request); end
        bus.button = 1'b0;
        tick_to(35);
    endtask

    task automatic test_starved();
        apply_reset();
        origin();
        bus.button = 1'b1;
        tick();
        tick_to(5);
        bus.button = 1'b0;
        tick_to(1005);
        checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL starved_edge1005: got %b want 0", bus.starved); end
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL starved_request_held: got %b want 1", bus.request); end
        tick_to(1006);
        checks++; if (bus.starved !== 1'b1) begin errors++; $display("FAIL starved_edge1006: got %b want 1", bus.starved); end
        tick_to(1009);
        bus.light_green = 1'b1;
        bus.light_red   = 1'b0;
        tick_to(1010);
        checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL starved_cleared: got %b want 0", bus.starved); end
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL starved_served: got %b want 0", bus.request); end
        checks++; if (bus.last_wait !== LW_STARVE) begin errors++; $display("FAIL starved_last_wait: got %0d want %0d", bus.last_wait, LW_STARVE); end
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        tick_to(1020);
    endtask

    task automatic test_fault();
        apply_reset();
        origin();
        bus.button = 1'b1;
        tick();
        tick_to(5);
        bus.button = 1'b0;
        tick_to(9);
        bus.light_red = 1'b0;
        tick_to(10);
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_dark_set: got %b want 1", bus.fault); end
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL fault_request_kept: got %b want 1", bus.request); end
        bus.light_red = 1'b1;
        tick_to(13);
        bus.light_green = 1'b1;
        bus.light_red   = 1'b0;
        tick_to(14);
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL fault_request_served: got %b want 0", bus.request); end
        checks++; if (bus.walk_lamp !== 1'b0) begin errors++; $display("FAIL fault_walk_blocked: got %b want 0", bus.walk_lamp); end
        checks++; if (bus.dont_walk_lamp !== 1'b1) begin errors++; $display("FAIL fault_dont_walk: got %b want 1", bus.dont_walk_lamp); end
        bus.light_green = 1'b0;
        bus.light_red   = 1'b1;
        tick_to(20);

        apply_reset();
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_cleared_by_reset: got %b want 0", bus.fault); end
        origin();
        bus.light_green = 1'b1;
        bus.light_red   = 1'b1;
        tick();
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_both_set: got %b want 1", bus.fault); end
        checks++; if (bus.walk_lamp !== 1'b0) begin errors++; $display("FAIL fault_both_walk: got %b want 0", bus.walk_lamp); end
        bus.light_green = 1'b0;
        tick_to(5);
        bus.light_green = 1'b1;
        bus.light_red   = 1'b0;
        tick_to(8);
        checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", bus.fault); end
        checks++; if (bus.walk_lamp !== 1'b0) begin errors++; $display("FAIL fault_sticky_walk: got %b want 0", bus.walk_lamp); end
        apply_reset();
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_reset_again: got %b want 0", bus.fault); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        origin();
        bus.button = 1'b1;
        tick();
        tick_to(5);
        bus.button = 1'b0;
        tick_to(8);
        checks++; if (bus.request !== 1'b1) begin errors++; $display("FAIL async_pre_request: got %b want 1", bus.request); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL async_request: got %b want 0", bus.request); end
        checks++; if (bus.wait_lamp !== 1'b0) begin errors++; $display("FAIL async_wait_lamp: got %b want 0", bus.wait_lamp); end
        checks++; if (bus.dont_walk_lamp !== 1'b1) begin errors++; $display("FAIL async_dont_walk: got %b want 1", bus.dont_walk_lamp); end
        checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL async_state_idle: got %0d want 0", dut.state); end
        #2;
        reset = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (bus.request !== 1'b0) begin errors++; $display("FAIL async_after_release: got %b want 0", bus.request); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_green_press();
        test_holdoff();
        test_starved();
        test_fault();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
